// File: rtl/service_arbiter_if.sv
// Bundle of the shared-UI signals between the service arbiter and its environment.
// slave  : arbiter side (switches, buttons, service results in; grant, pulses, display, load out)
// master : environment side (the reverse directions)
interface service_arbiter_if;
    logic [3:0]  spdt;
    logic        push_u;
    logic        push_d;
    logic        push_l;
    logic        push_r;
    logic [3:0]  svc_finish;
    logic [63:0] svc_num;
    logic [15:0] svc_sel;
    logic [15:0] cur_time;
    logic [3:0]  svc_en;
    logic        svc_u;
    logic        svc_d;
    logic        svc_l;
    logic        svc_r;
    logic [15:0] disp_num;
    logic [3:0]  disp_sel;
    logic        load_valid;
    logic [1:0]  load_svc;
    logic [15:0] load_num;
    logic        busy;
    logic        timeout_err;

    modport slave (
        input  spdt, push_u, push_d, push_l, push_r, svc_finish, svc_num, svc_sel, cur_time,
        output svc_en, svc_u, svc_d, svc_l, svc_r, disp_num, disp_sel,
               load_valid, load_svc, load_num, busy, timeout_err
    );

    modport master (
        output spdt, push_u, push_d, push_l, push_r, svc_finish, svc_num, svc_sel, cur_time,
        input  svc_en, svc_u, svc_d, svc_l, svc_r, disp_num, disp_sel,
               load_valid, load_svc, load_num, busy, timeout_err
    );
endinterface

// File: rtl/service_arbiter.sv
// Grants the push buttons and 4-digit display to one service at a time, turns raw
// buttons into one-cycle pulses for the granted service, and captures its result.
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset
//   sa    - service_arbiter_if.slave: spdt/push_*/svc_finish/svc_num/svc_sel/cur_time in;
//           svc_en/svc_*/disp_*/load_*/busy/timeout_err out (all registered)
module service_arbiter #(
    parameter int unsigned N_SVC       = 4,
    parameter int unsigned FIN_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    service_arbiter_if.slave sa
);
    localparam int unsigned IDX_W = $clog2(N_SVC);
    localparam int unsigned CNT_W = $clog2(FIN_TIMEOUT + 1);
    localparam int unsigned DIG_W = 16;
    localparam int unsigned SEL_W = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [IDX_W-1:0]  r_k;
    logic [IDX_W-1:0]  w_next_k;
    logic [IDX_W-1:0]  w_low_idx;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_capture;
    logic              w_timeout;
    logic [3:0]        w_btn;
    logic [3:0]        r_hist;
    logic [3:0]        w_pulse;
    logic [N_SVC-1:0]  w_en_next;
    logic [DIG_W-1:0]  w_num_k;
    logic [SEL_W-1:0]  w_sel_k;
    logic [DIG_W-1:0]  w_disp_num;
    logic [SEL_W-1:0]  w_disp_sel;

    logic [N_SVC-1:0]  r_svc_en;
    logic [3:0]        r_pulse;
    logic [DIG_W-1:0]  r_disp_num;
    logic [SEL_W-1:0]  r_disp_sel;
    logic              r_load_valid;
    logic [IDX_W-1:0]  r_load_svc;
    logic [DIG_W-1:0]  r_load_num;
    logic              r_busy;
    logic              r_timeout_err;

    // Buttons packed as {u, d, l, r}
    assign w_btn   = {sa.push_u, sa.push_d, sa.push_l, sa.push_r};
    assign w_num_k = sa.svc_num[int'(r_k) * DIG_W +: DIG_W];
    assign w_sel_k = sa.svc_sel[int'(r_k) * SEL_W +: SEL_W];

    // Lowest-index requesting switch wins the grant
    always_comb begin
        w_low_idx = '0;
        for (int i = N_SVC - 1; i >= 0; i--) begin
            if (sa.spdt[i]) begin
                w_low_idx = IDX_W'(i);
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_k     <= w_next_k;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic; finish from the granted service beats switch drop and timeout
    always_comb begin
        w_next     = r_state;
        w_next_k   = r_k;
        w_cnt_next = r_cnt;
        w_capture  = 1'b0;
        w_timeout  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|sa.spdt) begin
                    w_next   = S_ACTIVE;
                    w_next_k = w_low_idx;
                end
            end
            S_ACTIVE: begin
                if (sa.svc_finish[r_k]) begin
                    w_capture = 1'b1;
                    w_next    = S_IDLE;
                end else if (!sa.spdt[r_k]) begin
                    w_next     = S_WAIT;
                    w_cnt_next = '0;
                end
            end
            S_WAIT: begin
                if (sa.svc_finish[r_k]) begin
                    w_capture = 1'b1;
                    w_next    = S_IDLE;
                end else if (r_cnt == CNT_W'(FIN_TIMEOUT - 1)) begin
                    // This cycle's increment would reach FIN_TIMEOUT
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        w_pulse    = '0;
        w_en_next  = '0;
        w_disp_num = sa.cur_time;
        w_disp_sel = '0;
        if (r_state == S_ACTIVE) begin
            w_pulse = w_btn & ~r_hist;
        end
        if (w_next != S_IDLE) begin
            w_en_next = N_SVC'(1) << w_next_k;
        end
        if (r_state != S_IDLE) begin
            w_disp_num = w_num_k;
            w_disp_sel = w_sel_k;
        end
    end

    // Output registers; button history tracks raw inputs in every state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hist        <= '0;
            r_svc_en      <= '0;
            r_pulse       <= '0;
            r_disp_num    <= '0;
            r_disp_sel    <= '0;
            r_load_valid  <= 1'b0;
            r_load_svc    <= '0;
            r_load_num    <= '0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_hist        <= w_btn;
            r_svc_en      <= w_en_next;
            r_pulse       <= w_pulse;
            r_disp_num    <= w_disp_num;
            r_disp_sel    <= w_disp_sel;
            r_load_valid  <= w_capture;
            r_busy        <= (w_next != S_IDLE);
            r_timeout_err <= w_timeout;
            if (w_capture) begin
                r_load_num <= w_num_k;
                r_load_svc <= r_k;
            end
        end
    end

    assign sa.svc_en      = r_svc_en;
    assign sa.svc_u       = r_pulse[3];
    assign sa.svc_d       = r_pulse[2];
    assign sa.svc_l       = r_pulse[1];
    assign sa.svc_r       = r_pulse[0];
    assign sa.disp_num    = r_disp_num;
    assign sa.disp_sel    = r_disp_sel;
    assign sa.load_valid  = r_load_valid;
    assign sa.load_svc    = r_load_svc;
    assign sa.load_num    = r_load_num;
    assign sa.busy        = r_busy;
    assign sa.timeout_err = r_timeout_err;
endmodule

// File: tb/tb_service_arbiter.sv
// Testbench for service_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the arbitration rules.
module tb_service_arbiter;
    localparam int unsigned FIN_TIMEOUT = 16;

    logic clk;
    logic reset;
    service_arbiter_if bus ();

    service_arbiter #(.N_SVC(4), .FIN_TIMEOUT(FIN_TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .sa    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: owner is the granted service (-1 = none); draining means its switch dropped
    int          owner;
    bit          draining;
    int          waited;
    logic [3:0]  prev_btn;
    logic [3:0]  e_en;
    logic [3:0]  e_btn;
    logic [15:0] e_disp_num;
    logic [3:0]  e_disp_sel;
    logic        e_lv;
    logic [1:0]  e_ls;
    logic [15:0] e_ln;
    logic        e_busy;
    logic        e_to;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] pulses();
        return {bus.svc_u, bus.svc_d, bus.svc_l, bus.svc_r};
    endfunction

    // Advance the model by one clock using the inputs currently applied
    task automatic model_step();
        logic [3:0] btn;
        btn = {bus.push_u, bus.push_d, bus.push_l, bus.push_r};
        if (reset) begin
            owner = -1; draining = 0; waited = 0; prev_btn = '0;
            e_en = '0; e_btn = '0; e_disp_num = '0; e_disp_sel = '0;
            e_lv = 0; e_ls = '0; e_ln = '0; e_busy = 0; e_to = 0;
            return;
        end
        e_btn = (owner >= 0 && !draining) ? (btn & ~prev_btn) : 4'b0;
        prev_btn = btn;
        if (owner < 0) begin
            e_disp_num = bus.cur_time;
            e_disp_sel = '0;
        end else begin
            e_disp_num = bus.svc_num[owner*16 +: 16];
            e_disp_sel = bus.svc_sel[owner*4 +: 4];
        end
        e_lv = 0;
        e_to = 0;
        if (owner < 0) begin
            for (int i = 3; i >= 0; i--) if (bus.spdt[i]) owner = i;
            draining = 0;
        end else if (bus.svc_finish[owner]) begin
            e_ln  = bus.svc_num[owner*16 +: 16];
            e_ls  = 2'(owner);
            e_lv  = 1;
            owner = -1;
        end else if (!draining) begin
            if (!bus.spdt[owner]) begin
                draining = 1;
                waited   = 0;
            end
        end else begin
            waited++;
            if (waited == FIN_TIMEOUT) begin
                e_to  = 1;
                owner = -1;
            end
        end
        e_en   = (owner < 0) ? 4'b0 : (4'b1 << owner);
        e_busy = (owner >= 0);
    endtask

    task automatic run_cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check("svc_en",      64'(bus.svc_en),      64'(e_en));
        check("pulses",      64'(pulses()),        64'(e_btn));
        check("disp_num",    64'(bus.disp_num),    64'(e_disp_num));
        check("disp_sel",    64'(bus.disp_sel),    64'(e_disp_sel));
        check("load_valid",  64'(bus.load_valid),  64'(e_lv));
        check("load_svc",    64'(bus.load_svc),    64'(e_ls));
        check("load_num",    64'(bus.load_num),    64'(e_ln));
        check("busy",        64'(bus.busy),        64'(e_busy));
        check("timeout_err", 64'(bus.timeout_err), 64'(e_to));
    endtask

    initial begin
        logic [15:0] held_num;
        int to_seen;
        int lv_seen;

        reset = 1;
        bus.spdt = '0; bus.push_u = 0; bus.push_d = 0; bus.push_l = 0; bus.push_r = 0;
        bus.svc_finish = '0; bus.svc_num = 64'h4444_3333_2222_1111; bus.svc_sel = 16'h4321;
        bus.cur_time = 16'h0000;
        owner = -1; draining = 0; waited = 0; prev_btn = '0;

        run_cycle();
        run_cycle();
        check("rst_en", 64'(bus.svc_en), 64'h0);
        check("rst_ln", 64'(bus.load_num), 64'h0);
        reset = 0;

        // Display follows cur_time while idle
        bus.cur_time = 16'h1230;
        run_cycle();
        check("idle_disp", 64'(bus.disp_num), 64'h1230);
        check("idle_sel",  64'(bus.disp_sel), 64'h0);

        // Basic grant and a held button giving one pulse
        bus.spdt = 4'b0001;
        run_cycle();
        check("grant_en", 64'(bus.svc_en), 64'h1);
        check("grant_busy", 64'(bus.busy), 64'h1);
        bus.push_r = 1;
        run_cycle();
        check("r_pulse", 64'(bus.svc_r), 64'h1);
        run_cycle();
        check("r_held", 64'(bus.svc_r), 64'h0);
        run_cycle();
        bus.push_r = 0;

        // Result path
        bus.svc_num[15:0] = 16'h0938;
        bus.spdt = 4'b0000;
        run_cycle();
        run_cycle();
        run_cycle();
        bus.svc_finish = 4'b0001;
        run_cycle();
        check("res_lv",  64'(bus.load_valid), 64'h1);
        check("res_ln",  64'(bus.load_num), 64'h0938);
        check("res_ls",  64'(bus.load_svc), 64'h0);
        check("res_en",  64'(bus.svc_en), 64'h0);
        bus.svc_finish = '0;
        run_cycle();
        check("res_lv_once", 64'(bus.load_valid), 64'h0);

        // Priority, other switches ignored once granted
        bus.spdt = 4'b0110;
        run_cycle();
        check("prio_en", 64'(bus.svc_en), 64'h2);
        bus.spdt = 4'b1110;
        run_cycle();
        run_cycle();
        check("prio_hold", 64'(bus.svc_en), 64'h2);

        // Foreign finish ignored; buttons suppressed while waiting
        bus.svc_finish = 4'b1000;
        run_cycle();
        check("foreign_lv", 64'(bus.load_valid), 64'h0);
        bus.svc_finish = '0;
        bus.spdt = 4'b1100;
        run_cycle();
        bus.push_u = 1;
        run_cycle();
        check("wait_no_u", 64'(bus.svc_u), 64'h0);
        run_cycle();
        bus.push_u = 0;
        bus.svc_finish = 4'b0010;
        run_cycle();
        check("svc1_lv", 64'(bus.load_valid), 64'h1);
        bus.svc_finish = '0;
        run_cycle();
        check("regrant", 64'(bus.svc_en), 64'h4);

        // Timeout of service 2
        held_num = bus.load_num;
        bus.spdt = 4'b0000;
        run_cycle();
        to_seen = 0;
        lv_seen = 0;
        for (int i = 0; i < FIN_TIMEOUT - 1; i++) begin
            run_cycle();
            to_seen += int'(bus.timeout_err);
            lv_seen += int'(bus.load_valid);
        end
        check("to_early", 64'(to_seen), 64'h0);
        run_cycle();
        lv_seen += int'(bus.load_valid);
        check("to_fire", 64'(bus.timeout_err), 64'h1);
        check("to_no_lv", 64'(lv_seen), 64'h0);
        check("to_ln", 64'(bus.load_num), 64'(held_num));
        check("to_en", 64'(bus.svc_en), 64'h0);

        // Reset while active
        bus.spdt = 4'b0001;
        run_cycle();
        reset = 1;
        run_cycle();
        check("rst_act_en", 64'(bus.svc_en), 64'h0);
        check("rst_act_busy", 64'(bus.busy), 64'h0);
        check("rst_act_ln", 64'(bus.load_num), 64'h0);
        reset = 0;
        bus.spdt = '0;

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 9) == 0) bus.spdt[i] = ~bus.spdt[i];
                bus.svc_finish[i] = ($urandom_range(0, 15) == 0);
            end
            if ($urandom_range(0, 3) == 0) bus.push_u = ~bus.push_u;
            if ($urandom_range(0, 3) == 0) bus.push_d = ~bus.push_d;
            if ($urandom_range(0, 3) == 0) bus.push_l = ~bus.push_l;
            if ($urandom_range(0, 3) == 0) bus.push_r = ~bus.push_r;
            if ($urandom_range(0, 4) == 0) bus.svc_num = {$urandom, $urandom};
            if ($urandom_range(0, 4) == 0) bus.svc_sel = 16'($urandom);
            bus.cur_time = 16'($urandom);
            run_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
